exc_mem_unit: RTL and testbench

- Parametrised successor of the M-stage exception checker in the five-stage MIPS pipeline.
- Combinationally classifies load/store address faults (AdEL/AdES) against a configurable data-memory size and up to four device windows, and forwards upstream exception codes.
- Registers the classified code into the M/W pipeline register, with stall and flush support.
- Holds the first accepted exception in a request register until CP0 acknowledges it, exposing EPC and BadVAddr.

---
 rtl/exc_mem_unit.sv | 167 ++++++++++++++++
 tb/tb_exc_mem_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_mem_unit.sv
// M-stage exception checker: classifies lw/sw/lh/lhu/sh/lb/lbu/sb address faults
// (AdEL=4, AdES=5) against DM size and device windows, registers the code into
// M/W, and latches the first accepted exception until CP0 acknowledges it.
// Optional: define EXC_MEM_CNT_EN to build a saturating accepted-exception counter.
module exc_mem_unit #(
  parameter logic [31:0]  DM_BYTES    = 32'd8192,
  parameter int           DEV_N       = 2,
  parameter logic [127:0] DEV_BASE    = {32'h0, 32'h0, 32'h7f10, 32'h7f00},
  parameter logic [127:0] DEV_RD_LAST = {32'h0, 32'h0, 32'h7f43, 32'h7f0b},
  parameter logic [127:0] DEV_WR_LAST = {32'h0, 32'h0, 32'h7f43, 32'h7f07}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_m,
  input  logic [31:0] ao_m,
  input  logic [31:0] pc_m,
  input  logic [4:0]  exccode_e,
  input  logic        bd_e,
  input  logic        stall_m,
  input  logic        flush_m,
  input  logic        exc_ack,
  output logic [4:0]  exccode_m,
  output logic        bd_m,
  output logic [4:0]  exccode_w,
  output logic        bd_w,
  output logic        exc_req,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic [31:0] exc_badvaddr,
  output logic [15:0] exc_cnt
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [4:0] ADEL = 5'd4;
  localparam logic [4:0] ADES = 5'd5;

  logic [5:0]  opcode;
  logic        dm_ok;
  logic        dev_rd_hit;
  logic        dev_wr_hit;
  logic        adr_fault;
  logic        is_store;
  logic        capture;
  state_t      state_q;
  logic        exc_req_q;
  logic [4:0]  exc_code_q;
  logic [31:0] exc_epc_q;
  logic [31:0] exc_badvaddr_q;
  logic [4:0]  exccode_w_q;
  logic        bd_w_q;
  logic        unused_instr;

  assign opcode       = instr_m[31:26];
  assign unused_instr = ^instr_m[25:0];
  assign dm_ok        = (ao_m < DM_BYTES);

  // Device window hit detection; only the first DEV_N windows are live.
  always_comb begin
    dev_rd_hit = 1'b0;
    dev_wr_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < DEV_N) begin
        if ((ao_m >= DEV_BASE[32*i +: 32]) && (ao_m <= DEV_RD_LAST[32*i +: 32]))
          dev_rd_hit = 1'b1;
        if ((ao_m >= DEV_BASE[32*i +: 32]) && (ao_m <= DEV_WR_LAST[32*i +: 32]))
          dev_wr_hit = 1'b1;
      end
    end
  end

  // Per-opcode alignment/range check; devices are word-only.
  always_comb begin
    adr_fault = 1'b0;
    is_store  = 1'b0;
    case (opcode)
      6'h23: adr_fault = (ao_m[1:0] != 2'b00) || !(dm_ok || dev_rd_hit);
      6'h2B: begin
        is_store  = 1'b1;
        adr_fault = (ao_m[1:0] != 2'b00) || !(dm_ok || dev_wr_hit);
      end
      6'h21, 6'h25: adr_fault = ao_m[0] || !dm_ok;
      6'h29: begin
        is_store  = 1'b1;
        adr_fault = ao_m[0] || !dm_ok;
      end
      6'h20, 6'h24: adr_fault = !dm_ok;
      6'h28: begin
        is_store  = 1'b1;
        adr_fault = !dm_ok;
      end
      default: adr_fault = 1'b0;
    endcase
  end

  assign exccode_m = adr_fault ? (is_store ? ADES : ADEL) : exccode_e;
  assign bd_m      = bd_e;
  assign capture   = (state_q == IDLE) && (exccode_m != 5'd0) && !stall_m && !flush_m;

  // M/W pipeline register: flush beats stall.
  always_ff @(posedge clk) begin
    if (reset || flush_m) begin
      exccode_w_q <= 5'd0;
      bd_w_q      <= 1'b0;
    end else if (!stall_m) begin
      exccode_w_q <= exccode_m;
      bd_w_q      <= bd_m;
    end
  end

  // Capture FSM: latch first exception, hold until acked; faults during ack are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      exc_req_q      <= 1'b0;
      exc_code_q     <= 5'd0;
      exc_epc_q      <= 32'd0;
      exc_badvaddr_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            state_q        <= PEND;
            exc_req_q      <= 1'b1;
            exc_code_q     <= exccode_m;
            exc_epc_q      <= bd_e ? (pc_m - 32'd4) : pc_m;
            exc_badvaddr_q <= adr_fault ? ao_m : pc_m;
          end
        end
        PEND: begin
          if (exc_ack) begin
            state_q   <= IDLE;
            exc_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          exc_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_MEM_CNT_EN
  logic [15:0] cnt_q;

  // Saturating count of accepted exceptions.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= 16'd0;
    else if (capture && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  assign exc_cnt = cnt_q;
`else
  assign exc_cnt = 16'd0;
`endif

  assign exccode_w    = exccode_w_q;
  assign bd_w         = bd_w_q;
  assign exc_req      = exc_req_q;
  assign exc_code     = exc_code_q;
  assign exc_epc      = exc_epc_q;
  assign exc_badvaddr = exc_badvaddr_q;

endmodule

// File: tb/tb_exc_mem_unit.sv
// Directed bench for exc_mem_unit: vector table for the combinational classifier,
// hand sequences for capture, ack, stall/flush and reset corner cases.
module tb_exc_mem_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instr_m;
  logic [31:0] ao_m;
  logic [31:0] pc_m;
  logic [4:0]  exccode_e;
  logic        bd_e;
  logic        stall_m;
  logic        flush_m;
  logic        exc_ack;
  logic [4:0]  exccode_m;
  logic        bd_m;
  logic [4:0]  exccode_w;
  logic        bd_w;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic [15:0] exc_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_LH = 6'h21, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SH = 6'h29, OP_LB = 6'h20, OP_LBU = 6'h24, OP_SB = 6'h28;
  localparam logic [5:0] OP_ALU = 6'h00;

  exc_mem_unit dut (
    .clk(clk), .reset(reset), .instr_m(instr_m), .ao_m(ao_m), .pc_m(pc_m),
    .exccode_e(exccode_e), .bd_e(bd_e), .stall_m(stall_m), .flush_m(flush_m),
    .exc_ack(exc_ack), .exccode_m(exccode_m), .bd_m(bd_m), .exccode_w(exccode_w),
    .bd_w(bd_w), .exc_req(exc_req), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_badvaddr(exc_badvaddr), .exc_cnt(exc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] ao;
    logic [4:0]  ec;
    logic        bd;
    logic [4:0]  exp_code;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] pc,
                       input logic [4:0] ec, input logic bd);
    instr_m   = {op, 26'h0};
    ao_m      = ao;
    pc_m      = pc;
    exccode_e = ec;
    bd_e      = bd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string name);
`ifdef EXC_MEM_CNT_EN
    chk(name, {16'h0, exc_cnt}, exp_cnt);
`else
    chk(name, {16'h0, exc_cnt}, 32'd0);
`endif
  endtask

  initial begin
    vecs[0]  = '{OP_LW,  32'h1FFE, 5'd0,  1'b0, 5'd4};
    vecs[1]  = '{OP_SW,  32'h7F08, 5'd0,  1'b1, 5'd5};
    vecs[2]  = '{OP_LW,  32'h7F08, 5'd0,  1'b0, 5'd0};
    vecs[3]  = '{OP_LW,  32'h7F40, 5'd0,  1'b0, 5'd0};
    vecs[4]  = '{OP_SH,  32'h7F10, 5'd0,  1'b0, 5'd5};
    vecs[5]  = '{OP_LB,  32'h1FFF, 5'd0,  1'b1, 5'd0};
    vecs[6]  = '{OP_LBU, 32'h2000, 5'd0,  1'b0, 5'd4};
    vecs[7]  = '{OP_LW,  32'h1FFC, 5'd0,  1'b0, 5'd0};
    vecs[8]  = '{OP_LW,  32'h2000, 5'd0,  1'b0, 5'd4};
    vecs[9]  = '{OP_SW,  32'h7F44, 5'd0,  1'b0, 5'd5};
    vecs[10] = '{OP_LH,  32'h1FFE, 5'd0,  1'b0, 5'd0};
    vecs[11] = '{OP_LHU, 32'h0001, 5'd0,  1'b0, 5'd4};
    vecs[12] = '{OP_ALU, 32'h0003, 5'd12, 1'b0, 5'd12};
    vecs[13] = '{OP_SB,  32'h2000, 5'd12, 1'b0, 5'd5};
    vecs[14] = '{OP_LW,  32'h7F0C, 5'd0,  1'b0, 5'd4};
    vecs[15] = '{OP_SW,  32'h7F04, 5'd0,  1'b0, 5'd0};

    reset = 1'b1; stall_m = 1'b0; flush_m = 1'b0; exc_ack = 1'b0;
    drive(OP_ALU, 32'h0, 32'h0, 5'd0, 1'b0);
    tick; tick;
    reset = 1'b0;
    #1;
    chk("rst_req", {31'h0, exc_req}, 32'd0);
    chk("rst_code", {27'h0, exc_code}, 32'd0);
    chk("rst_epc", exc_epc, 32'd0);
    chk("rst_bad", exc_badvaddr, 32'd0);
    chk("rst_w", {27'h0, exccode_w}, 32'd0);
    chk("rst_bdw", {31'h0, bd_w}, 32'd0);
    chk_cnt("rst_cnt");

    // Classifier table; stalled so nothing is captured.
    stall_m = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].op, vecs[i].ao, 32'h1000, vecs[i].ec, vecs[i].bd);
      #1;
      chk($sformatf("vec%0d_code", i), {27'h0, exccode_m}, {27'h0, vecs[i].exp_code});
      chk($sformatf("vec%0d_bd", i), {31'h0, bd_m}, {31'h0, vecs[i].bd});
      tick;
    end
    chk("tbl_w_hold", {27'h0, exccode_w}, 32'd0);
    chk("tbl_no_req", {31'h0, exc_req}, 32'd0);

    // Misaligned lw captured.
    stall_m = 1'b0;
    drive(OP_LW, 32'h1FFE, 32'h1000, 5'd0, 1'b0);
    #1;
    chk("a_m", {27'h0, exccode_m}, 32'd4);
    tick; exp_cnt++;
    chk("a_req", {31'h0, exc_req}, 32'd1);
    chk("a_code", {27'h0, exc_code}, 32'd4);
    chk("a_bad", exc_badvaddr, 32'h1FFE);
    chk("a_epc", exc_epc, 32'h1000);
    chk("a_w", {27'h0, exccode_w}, 32'd4);

    // Second fault while pending is ignored.
    drive(OP_SW, 32'h7F08, 32'h2000, 5'd0, 1'b1);
    tick;
    chk("b_code", {27'h0, exc_code}, 32'd4);
    chk("b_bad", exc_badvaddr, 32'h1FFE);
    chk("b_epc", exc_epc, 32'h1000);
    chk("b_w", {27'h0, exccode_w}, 32'd5);
    chk("b_bdw", {31'h0, bd_w}, 32'd1);

    // Ack with a simultaneous fault: fault dropped.
    exc_ack = 1'b1;
    drive(OP_LW, 32'h0002, 32'h2004, 5'd0, 1'b0);
    tick;
    exc_ack = 1'b0;
    chk("c_req", {31'h0, exc_req}, 32'd0);
    drive(OP_ALU, 32'h0, 32'h2008, 5'd0, 1'b0);
    tick;
    chk("c_req2", {31'h0, exc_req}, 32'd0);
    chk_cnt("c_cnt");

    // Overflow from E in a delay slot.
    drive(OP_ALU, 32'h1234, 32'h3008, 5'd12, 1'b1);
    tick; exp_cnt++;
    chk("d_code", {27'h0, exc_code}, 32'd12);
    chk("d_epc", exc_epc, 32'h3004);
    chk("d_bad", exc_badvaddr, 32'h3008);
    chk("d_bdw", {31'h0, bd_w}, 32'd1);
    exc_ack = 1'b1;
    drive(OP_ALU, 32'h0, 32'h300C, 5'd0, 1'b0);
    tick;
    exc_ack = 1'b0;

    // EPC wrap at pc 0 with bd.
    drive(OP_ALU, 32'h0, 32'h0, 5'd10, 1'b1);
    tick; exp_cnt++;
    chk("e_epc", exc_epc, 32'hFFFF_FFFC);
    chk("e_bad", exc_badvaddr, 32'h0);
    chk("e_w", {27'h0, exccode_w}, 32'd10);
    chk_cnt("e_cnt");

    // Stalled ack cycle: exccode_w holds 10.
    stall_m = 1'b1; exc_ack = 1'b1;
    drive(OP_ALU, 32'h0, 32'h4000, 5'd0, 1'b0);
    tick;
    exc_ack = 1'b0;
    chk("f_req", {31'h0, exc_req}, 32'd0);
    chk("f_w_hold", {27'h0, exccode_w}, 32'd10);
    // Stalled fault is not captured.
    drive(OP_LW, 32'h1FFE, 32'h4004, 5'd0, 1'b0);
    tick;
    chk("f_nocap", {31'h0, exc_req}, 32'd0);
    chk("f_w_hold2", {27'h0, exccode_w}, 32'd10);
    // Flush beats stall.
    flush_m = 1'b1;
    tick;
    chk("g_w", {27'h0, exccode_w}, 32'd0);
    chk("g_bdw", {31'h0, bd_w}, 32'd0);
    chk("g_nocap", {31'h0, exc_req}, 32'd0);
    flush_m = 1'b0; stall_m = 1'b0;

    // Reset while pending.
    drive(OP_SB, 32'h2100, 32'h5000, 5'd0, 1'b0);
    tick; exp_cnt++;
    chk("h_req", {31'h0, exc_req}, 32'd1);
    chk("h_code", {27'h0, exc_code}, 32'd5);
    chk_cnt("h_cnt");
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_cnt = 0;
    chk("h_rst_req", {31'h0, exc_req}, 32'd0);
    chk("h_rst_code", {27'h0, exc_code}, 32'd0);
    chk("h_rst_epc", exc_epc, 32'd0);
    chk("h_rst_bad", exc_badvaddr, 32'd0);
    chk_cnt("h_rst_cnt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
